// File: rtl/imem_fetch.sv
// Instruction-fetch initiator: drives ROM word addresses, buffers {pc, inst} pairs for decode, and flushes on redirect.
// Optional macro IMEM_FETCH_BYPASS_EN forwards the ROM response straight to decode when the buffer is empty.
module imem_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [29:0] RESET_PC = 30'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [29:0] addr,
    input  logic [31:0] inst,
    input  logic        redirect,
    input  logic [29:0] redirect_pc,
    output logic        fe_valid,
    input  logic        fe_ready,
    output logic [31:0] fe_inst,
    output logic [29:0] fe_pc
);
    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [29:0]   fetch_pc_q, fetch_pc_d;
    logic          pend_v_q, pend_v_d;
    logic [29:0]   pend_pc_q, pend_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [29:0]   buf_pc_q   [DEPTH];
    logic [31:0]   buf_inst_q [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic          bypass;
    logic          buf_nonempty;
    logic [CW:0]   credit;

    assign addr         = redirect ? redirect_pc : fetch_pc_q;
    assign buf_nonempty = (count_q != '0);

    // Credit ignores a same-cycle pop so an in-flight response always has a free slot.
    assign credit = {1'b0, count_q} + {{CW{1'b0}}, pend_v_q};
    assign issue  = redirect || (credit < DEPTH_C);

`ifdef IMEM_FETCH_BYPASS_EN
    assign bypass = !buf_nonempty && pend_v_q && !redirect;
`else
    assign bypass = 1'b0;
`endif

    assign fe_valid = buf_nonempty || bypass;
    assign fe_inst  = bypass ? inst      : buf_inst_q[head_q];
    assign fe_pc    = bypass ? pend_pc_q : buf_pc_q[head_q];

    assign pop  = buf_nonempty && fe_ready;
    assign push = pend_v_q && !redirect && !(bypass && fe_ready);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_v_d   = 1'b0;
        pend_pc_d  = pend_pc_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (issue) begin
            pend_v_d   = 1'b1;
            pend_pc_d  = addr;
            fetch_pc_d = addr + 30'd1;
        end

        if (redirect) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            pend_v_q   <= 1'b0;
            pend_pc_q  <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_v_q   <= pend_v_d;
            pend_pc_q  <= pend_pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Storage is cleared on reset so an empty buffer presents pc 0 / inst 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc_q[i]   <= '0;
                buf_inst_q[i] <= '0;
            end
        end else if (push) begin
            buf_pc_q[tail_q]   <= pend_pc_q;
            buf_inst_q[tail_q] <= inst;
        end
    end

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: ROM model plus an accepted-stream reference model (consecutive pcs, restarted by redirect).
module tb_imem_fetch;
    localparam int          DEPTH    = 4;
    localparam logic [29:0] RESET_PC = 30'h0;
`ifdef IMEM_FETCH_BYPASS_EN
    localparam int          LAT      = 1;
`else
    localparam int          LAT      = 2;
`endif

    logic        clk;
    logic        rst;
    logic [29:0] addr;
    logic [31:0] inst;
    logic        redirect;
    logic [29:0] redirect_pc;
    logic        fe_valid;
    logic        fe_ready;
    logic [31:0] fe_inst;
    logic [29:0] fe_pc;

    int          checks = 0;
    int          passed = 0;

    logic        s_valid;
    logic        s_ready;
    logic [29:0] s_pc;
    logic [29:0] s_addr;
    logic [29:0] s_exp;
    logic [31:0] s_inst;
    logic [29:0] exp_pc;

    imem_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .inst        (inst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fe_valid    (fe_valid),
        .fe_ready    (fe_ready),
        .fe_inst     (fe_inst),
        .fe_pc       (fe_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rom(input logic [29:0] a);
        return {2'b00, a} ^ 32'hA5A50000;
    endfunction

    // Synchronous ROM: registers addr on each rising edge.
    always @(posedge clk) inst <= rom(addr);

    // One cycle: snapshot outputs on the falling edge, advance the stream model, step past the rising edge.
    task automatic tick();
        @(negedge clk);
        s_valid = fe_valid;
        s_ready = fe_ready;
        s_pc    = fe_pc;
        s_inst  = fe_inst;
        s_addr  = addr;
        s_exp   = exp_pc;
        if (fe_valid && fe_ready) exp_pc = exp_pc + 30'd1;
        if (redirect) exp_pc = redirect_pc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if (fe_valid !== 1'b0 || fe_pc !== 30'd0 || fe_inst !== 32'd0) begin
            $display("FAIL reset_outputs: got valid=%0b pc=%h inst=%h, expected 0/0/0", fe_valid, fe_pc, fe_inst);
        end else passed++;
        checks++;
        if (addr !== RESET_PC) $display("FAIL reset_addr: got %h expected %h", addr, RESET_PC);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (fe_valid !== 1'b0) $display("FAIL reset_hold_valid: got %0b expected 0", fe_valid);
        else passed++;
    endtask

    task automatic test_startup();
        exp_pc   = RESET_PC;
        fe_ready = 1'b1;
        redirect = 1'b0;
        rst      = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (c < LAT) begin
                if (s_valid !== 1'b0) $display("FAIL startup_latency c%0d: got valid=%0b expected 0", c, s_valid);
                else passed++;
            end else begin
                if (s_valid !== 1'b1 || s_pc !== s_exp)
                    $display("FAIL startup_pc c%0d: got valid=%0b pc=%h expected valid=1 pc=%h", c, s_valid, s_pc, s_exp);
                else passed++;
                checks++;
                if (s_inst !== rom(s_exp)) $display("FAIL startup_inst c%0d: got %h expected %h", c, s_inst, rom(s_exp));
                else passed++;
            end
            if (s_valid && s_pc == 30'd3) begin
                checks++;
                if (s_inst !== 32'hA5A50003) $display("FAIL inst_pc3: got %h expected a5a50003", s_inst);
                else passed++;
            end
        end
    endtask

    task automatic test_stall();
        fe_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (s_valid !== 1'b1 || s_pc !== s_exp)
                $display("FAIL stall_head c%0d: got valid=%0b pc=%h expected valid=1 pc=%h", c, s_valid, s_pc, s_exp);
            else passed++;
        end
        checks++;
        if (s_addr !== s_exp + 30'(DEPTH))
            $display("FAIL stall_no_issue: got addr=%h expected %h", s_addr, s_exp + 30'(DEPTH));
        else passed++;
        fe_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (s_valid !== 1'b1 || s_pc !== s_exp)
                $display("FAIL stall_resume c%0d: got valid=%0b pc=%h expected valid=1 pc=%h", c, s_valid, s_pc, s_exp);
            else passed++;
            checks++;
            if (s_inst !== rom(s_exp)) $display("FAIL stall_resume_inst c%0d: got %h expected %h", c, s_inst, rom(s_exp));
            else passed++;
        end
    endtask

    task automatic test_redirect(input logic [29:0] target);
        fe_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = target;
        tick();
        redirect = 1'b0;
        if (s_valid) begin
            checks++;
            if (s_pc !== s_exp) $display("FAIL redirect_cycle_pc: got %h expected %h", s_pc, s_exp);
            else passed++;
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (k < LAT) begin
                if (s_valid !== 1'b0) $display("FAIL redirect_bubble k%0d: got valid=%0b expected 0", k, s_valid);
                else passed++;
            end else begin
                if (s_valid !== 1'b1 || s_pc !== s_exp || s_pc !== target + 30'(k - LAT))
                    $display("FAIL redirect_pc k%0d: got valid=%0b pc=%h expected valid=1 pc=%h", k, s_valid, s_pc, target + 30'(k - LAT));
                else passed++;
                checks++;
                if (s_inst !== rom(s_exp)) $display("FAIL redirect_inst k%0d: got %h expected %h", k, s_inst, rom(s_exp));
                else passed++;
            end
        end
    endtask

    task automatic test_redirect_handshake();
        logic [29:0] consumed;
        fe_ready = 1'b0;
        repeat (5) tick();
        fe_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 30'h200;
        tick();
        redirect = 1'b0;
        consumed = s_exp;
        checks++;
        if (s_valid !== 1'b1 || s_pc !== consumed)
            $display("FAIL hs_redirect_accept: got valid=%0b pc=%h expected valid=1 pc=%h", s_valid, s_pc, consumed);
        else passed++;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (s_valid) begin
                checks++;
                if (s_pc === consumed || s_pc !== s_exp)
                    $display("FAIL hs_redirect_after k%0d: got pc=%h expected %h", k, s_pc, s_exp);
                else passed++;
            end
            if (k == LAT) begin
                checks++;
                if (s_valid !== 1'b1 || s_pc !== 30'h200)
                    $display("FAIL hs_redirect_first: got valid=%0b pc=%h expected valid=1 pc=200", s_valid, s_pc);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_midstream();
        fe_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        checks++;
        if (fe_valid !== 1'b0 || addr !== RESET_PC || fe_pc !== 30'd0 || fe_inst !== 32'd0)
            $display("FAIL midreset_outputs: got valid=%0b addr=%h pc=%h inst=%h expected 0/%h/0/0", fe_valid, addr, fe_pc, fe_inst, RESET_PC);
        else passed++;
        @(posedge clk);
        #1;
        exp_pc   = RESET_PC;
        fe_ready = 1'b1;
        rst      = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (c < LAT) begin
                if (s_valid !== 1'b0) $display("FAIL midreset_latency c%0d: got valid=%0b expected 0", c, s_valid);
                else passed++;
            end else if (s_valid !== 1'b1 || s_pc !== s_exp || (c == LAT && s_pc !== RESET_PC)) begin
                $display("FAIL midreset_pc c%0d: got valid=%0b pc=%h expected valid=1 pc=%h", c, s_valid, s_pc, s_exp);
            end else passed++;
        end
    endtask

    task automatic test_random();
        int accepted = 0;
        for (int c = 0; c < 400; c++) begin
            fe_ready    = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 1) == 1) ? 30'($urandom)
                                                      : 30'h3FFFFFFC + 30'($urandom_range(0, 3));
            tick();
            if (s_valid) begin
                checks++;
                if (s_pc !== s_exp) $display("FAIL random_pc c%0d: got %h expected %h", c, s_pc, s_exp);
                else passed++;
                checks++;
                if (s_inst !== rom(s_exp)) $display("FAIL random_inst c%0d: got %h expected %h", c, s_inst, rom(s_exp));
                else passed++;
            end
            if (s_valid && s_ready) accepted++;
        end
        redirect = 1'b0;
        fe_ready = 1'b1;
        checks++;
        if (accepted < 100) $display("FAIL random_throughput: got %0d accepted expected at least 100", accepted);
        else passed++;
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        fe_ready    = 1'b1;
        exp_pc      = RESET_PC;
        #3;
        test_reset();
        test_startup();
        test_stall();
        test_redirect(30'h100);
        test_redirect_handshake();
        test_redirect(30'h3FFFFFFE);
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
